// File: rtl/countdown_pkg.sv
// Shared types and limits for the hh:mm:ss countdown timer.
// Field-select codes and the clamp helper are used by the load path.
package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } tstate_t;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [5:0] HR_MAX  = 6'd23;

   localparam logic [1:0] SEL_SEC = 2'b00;
   localparam logic [1:0] SEL_MIN = 2'b01;
   localparam logic [1:0] SEL_HR  = 2'b10;

   function automatic logic [5:0] clamp6(
      input logic [5:0] v,
      input logic [5:0] m
   );
      return (v > m) ? m : v;
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Key, load and display bundle between the board top and the countdown timer.
// The master drives the key and load controls; the slave returns the time.
interface countdown_timer_if;

   logic       key_n;
   logic       load;
   logic [1:0] load_sel;
   logic [5:0] load_val;
   logic [4:0] hh;
   logic [5:0] mm;
   logic [5:0] ss;
   logic       running;
   logic       done;
   logic       tick;

   modport master (
      output key_n, load, load_sel, load_val,
      input  hh, mm, ss, running, done, tick
   );

   modport slave (
      input  key_n, load, load_sel, load_val,
      output hh, mm, ss, running, done, tick
   );

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// One-cycle strobe every TICK_DIV enabled cycles.
// The count is held at zero while en is low.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en || cnt_q == LAST) cnt_d = '0;
      else                      cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss countdown timer with single start/pause key.
// Loads clamp to legal ranges; completion raises done.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input logic           clk,
   input logic           rst,
   countdown_timer_if.slave bus
);

   logic    key_s1_q, key_s2_q, key_prev_q;
   logic    press;
   tstate_t state_q, state_d;
   logic [4:0] hh_q, hh_d, dec_hh;
   logic [5:0] mm_q, mm_d, dec_mm;
   logic [5:0] ss_q, ss_d, dec_ss;
   logic    running_q, running_d;
   logic    done_q, done_d;
   logic    tick_q, tick_d;
   logic    run_en, tk, step, nz, dec_zero;

   // released level is 1, so reset never fakes a press
   always_ff @(posedge clk) begin
      if (rst) begin
         key_s1_q   <= 1'b1;
         key_s2_q   <= 1'b1;
         key_prev_q <= 1'b1;
      end else begin
         key_s1_q   <= bus.key_n;
         key_s2_q   <= key_s1_q;
         key_prev_q <= key_s2_q;
      end
   end

   assign press  = key_prev_q & ~key_s2_q;
   assign run_en = (state_q == RUN);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (run_en),
      .tick (tk)
   );

   assign step = run_en & tk;
   assign nz   = |{hh_q, mm_q, ss_q};

   always_comb begin
      dec_hh = hh_q;
      dec_mm = mm_q;
      dec_ss = ss_q;
      if (ss_q != 6'd0) begin
         dec_ss = ss_q - 6'd1;
      end else if (mm_q != 6'd0) begin
         dec_mm = mm_q - 6'd1;
         dec_ss = SEC_MAX;
      end else if (hh_q != 5'd0) begin
         dec_hh = hh_q - 5'd1;
         dec_mm = MIN_MAX;
         dec_ss = SEC_MAX;
      end
   end

   assign dec_zero = ~|{dec_hh, dec_mm, dec_ss};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (press && nz) state_d = RUN;
         RUN: begin
            if (step && dec_zero) state_d = DONE;
            else if (press)       state_d = PAUSE;
         end
         PAUSE:   if (press) state_d = nz ? RUN : IDLE;
         DONE:    if (press || bus.load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // load is blocked only in RUN, where the decrement owns the fields
   always_comb begin
      hh_d = hh_q;
      mm_d = mm_q;
      ss_d = ss_q;
      if (step) begin
         hh_d = dec_hh;
         mm_d = dec_mm;
         ss_d = dec_ss;
      end else if (bus.load && !run_en) begin
         unique case (bus.load_sel)
            SEL_SEC: ss_d = clamp6(bus.load_val, SEC_MAX);
            SEL_MIN: mm_d = clamp6(bus.load_val, MIN_MAX);
            SEL_HR:  hh_d = 5'(clamp6(bus.load_val, HR_MAX));
            default: ;
         endcase
      end
   end

   always_comb begin
      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
      tick_d    = step;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hh_q      <= '0;
         mm_q      <= '0;
         ss_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hh_q      <= hh_d;
         mm_q      <= mm_d;
         ss_q      <= ss_d;
         running_q <= running_d;
         done_q    <= done_d;
         tick_q    <= tick_d;
      end
   end

   assign bus.hh      = hh_q;
   assign bus.mm      = mm_q;
   assign bus.ss      = ss_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
   assign bus.tick    = tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_countdown_timer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   countdown_timer_if bus();

   countdown_timer #(.TICK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one-cycle key pulse; returns on the cycle the state has updated
   task automatic press();
      bus.key_n = 1'b0;
      step(1);
      bus.key_n = 1'b1;
      step(2);
   endtask

   task automatic ld(input logic [1:0] sel, input logic [5:0] val);
      bus.load     = 1'b1;
      bus.load_sel = sel;
      bus.load_val = val;
      step(1);
      bus.load     = 1'b0;
   endtask

   initial begin
      bus.key_n    = 1'b1;
      bus.load     = 1'b0;
      bus.load_sel = 2'b11;
      bus.load_val = 6'd0;
      step(2);
      check("rst_hh", bus.hh, 0);
      check("rst_mm", bus.mm, 0);
      check("rst_ss", bus.ss, 0);
      check("rst_run", bus.running, 0);
      check("rst_done", bus.done, 0);
      check("rst_tick", bus.tick, 0);
      rst = 1'b0;
      step(1);

      // count down from 5 seconds
      ld(2'b00, 6'd5);
      check("ld_ss5", bus.ss, 5);
      press();
      check("start_run", bus.running, 1);
      check("start_ss", bus.ss, 5);
      for (int i = 1; i <= 5; i++) begin
         step(3);
         check("cd_notick", bus.tick, 0);
         step(1);
         check("cd_ss", bus.ss, 5 - i);
         check("cd_tick", bus.tick, 1);
      end
      check("cd_done", bus.done, 1);
      check("cd_run0", bus.running, 0);
      step(1);
      check("cd_tick_off", bus.tick, 0);

      // press in DONE returns to IDLE
      press();
      check("done_clr", bus.done, 0);
      check("done_run", bus.running, 0);

      // clamps, and the unused select writes nothing
      ld(2'b00, 6'd63);
      ld(2'b01, 6'd63);
      ld(2'b10, 6'd63);
      ld(2'b11, 6'd7);
      check("clamp_ss", bus.ss, 59);
      check("clamp_mm", bus.mm, 59);
      check("clamp_hh", bus.hh, 23);

      // load ignored while running
      press();
      check("run2", bus.running, 1);
      ld(2'b00, 6'd3);
      ld(2'b10, 6'd3);
      check("runld_ss", bus.ss, 59);
      check("runld_hh", bus.hh, 23);
      step(2);
      check("runld_dec", bus.ss, 58);
      press();
      check("pause_run0", bus.running, 0);
      check("pause_ss", bus.ss, 58);

      // hour borrow
      ld(2'b10, 6'd1);
      ld(2'b01, 6'd0);
      ld(2'b00, 6'd0);
      check("borrow_ld_hh", bus.hh, 1);
      press();
      check("borrow_run", bus.running, 1);
      step(4);
      check("borrow_hh", bus.hh, 0);
      check("borrow_mm", bus.mm, 59);
      check("borrow_ss", bus.ss, 59);
      check("borrow_tick", bus.tick, 1);

      // pause, zero the time, press in PAUSE -> IDLE, press in IDLE ignored
      press();
      check("p2_run0", bus.running, 0);
      ld(2'b01, 6'd0);
      ld(2'b00, 6'd0);
      press();
      check("p2i_run", bus.running, 0);
      check("p2i_done", bus.done, 0);
      press();
      check("idle0_run", bus.running, 0);
      step(4);
      check("idle0_ss", bus.ss, 0);

      // pause keeps value, resume restarts the second
      ld(2'b00, 6'd10);
      press();
      check("p10_run", bus.running, 1);
      press();
      check("p10_pause", bus.running, 0);
      check("p10_ss", bus.ss, 10);
      step(6);
      check("p10_hold", bus.ss, 10);
      press();
      check("res_run", bus.running, 1);
      step(3);
      check("res_ss_pre", bus.ss, 10);
      check("res_notick", bus.tick, 0);
      step(1);
      check("res_ss", bus.ss, 9);
      check("res_tick", bus.tick, 1);

      // press lands on the tick that takes ss 3 -> 2
      step(25);
      check("co_ss3", bus.ss, 3);
      press();
      check("co_ss2", bus.ss, 2);
      check("co_tick", bus.tick, 1);
      check("co_run0", bus.running, 0);
      check("co_done0", bus.done, 0);
      step(4);
      check("co_hold", bus.ss, 2);

      // reset mid-run
      press();
      step(4);
      check("rr_ss1", bus.ss, 1);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("rr_ss", bus.ss, 0);
      check("rr_run", bus.running, 0);
      check("rr_done", bus.done, 0);
      check("rr_tick", bus.tick, 0);
      ld(2'b00, 6'd2);
      press();
      check("rr_run2", bus.running, 1);
      step(4);
      check("rr_dec", bus.ss, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
